// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RISC-V control FSM: IF/ID/EX/MEM/WB with memory-wait watchdog (FAULT).
// Optional macro ECALL_HALT_EN: ECALL in ID enters a sticky HALT state.
module multi_cycle_control_unit #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] part_of_inst,
    input  logic       mem_ready,
    input  logic       bcond,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_source,
    output logic       is_halted,
    output logic       mem_fault
);

    localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
`ifdef ECALL_HALT_EN
    localparam logic [6:0] OP_ECALL     = 7'b1110011;
`endif

    typedef enum logic [2:0] {
        S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT, S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // A not-taken branch leaves PC unchanged; the following IF advances it by 4.
    logic             pc_adv_q, pc_adv_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IF;
            cnt_q    <= '0;
            pc_adv_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_adv_q <= pc_adv_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_adv_d = pc_adv_q;
        case (state_q)
            S_IF: begin
                if (mem_ready) begin
                    state_d  = S_ID;
                    pc_adv_d = 1'b0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_FAULT;
                end
            end
            S_ID: begin
`ifdef ECALL_HALT_EN
                state_d = (part_of_inst == OP_ECALL) ? S_HALT : S_EX;
`else
                state_d = S_EX;
`endif
            end
            S_EX: begin
                case (part_of_inst)
                    OP_ARITH, OP_ARITH_IMM, OP_JAL, OP_JALR,
                    OP_LUI, OP_AUIPC:      state_d = S_WB;
                    OP_LOAD, OP_STORE:     state_d = S_MEM;
                    OP_BRANCH: begin
                        state_d  = S_IF;
                        pc_adv_d = ~bcond;
                    end
                    default:               state_d = S_IF;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (part_of_inst == OP_LOAD) ? S_WB : S_IF;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_FAULT;
                end
            end
            S_WB:    state_d = S_IF;
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IF;
        endcase

        // Counter restarts on every state change, so it always starts at 0 in IF/MEM.
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == S_IF || state_q == S_MEM) && !mem_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        pc_source     = 1'b0;
        is_halted     = 1'b0;
        mem_fault     = 1'b0;
        case (state_q)
            S_IF: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready & pc_adv_q;
            end
            S_ID: alu_src_b = 2'd2;
            S_EX: begin
                case (part_of_inst)
                    OP_ARITH: alu_src_a = 1'b1;
                    OP_ARITH_IMM, OP_LOAD, OP_STORE, OP_JALR: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'd2;
                    end
                    OP_BRANCH: begin
                        alu_src_a     = 1'b1;
                        pc_write_cond = 1'b1;
                        pc_source     = 1'b1;
                    end
                    OP_JAL: ;
                    OP_LUI, OP_AUIPC: alu_src_b = 2'd2;
                    default: begin
                        pc_write  = 1'b1;
                        alu_src_b = 2'd1;
                    end
                endcase
            end
            S_MEM: begin
                i_or_d = 1'b1;
                if (part_of_inst == OP_LOAD) begin
                    mem_read = 1'b1;
                end else if (part_of_inst == OP_STORE) begin
                    mem_write = 1'b1;
                    alu_src_b = 2'd1;
                    pc_write  = mem_ready;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                mem_to_reg = (part_of_inst == OP_LOAD);
                if (part_of_inst == OP_JAL) begin
                    pc_source = 1'b1;
                end else if (part_of_inst == OP_JALR) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                end else begin
                    alu_src_b = 2'd1;
                end
            end
            S_HALT: begin
`ifdef ECALL_HALT_EN
                is_halted = 1'b1;
`else
                is_halted = 1'b0;
`endif
            end
            S_FAULT: mem_fault = 1'b1;
            default: ;
        endcase
        // An access interrupted by reset must not leave a write strobe behind.
        if (!reset_n) begin
            ir_write = 1'b0;
            pc_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Scoreboard bench for multi_cycle_control_unit: directed per-cycle vectors, queue-based checker.
module tb_multi_cycle_control_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] part_of_inst;
    logic       mem_ready;
    logic       bcond;
    logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
    logic       mem_to_reg, reg_write, alu_src_a, pc_source, is_halted, mem_fault;
    logic [1:0] alu_src_b;

    multi_cycle_control_unit #(.WAIT_MAX(15)) dut (
        .clk(clk), .reset_n(reset_n), .part_of_inst(part_of_inst),
        .mem_ready(mem_ready), .bcond(bcond),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_source(pc_source),
        .is_halted(is_halted), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    // Field order: pw pwc irw iod | mr mw m2r rw | asa | asb[1:0] | pcs hlt flt
    localparam logic [13:0] IF_W   = 14'b0000_1000_0_01_000;
    localparam logic [13:0] IF_R   = 14'b0010_1000_0_01_000;
    localparam logic [13:0] IF_RA  = 14'b1010_1000_0_01_000;
    localparam logic [13:0] ID_S   = 14'b0000_0000_0_10_000;
    localparam logic [13:0] EX_R   = 14'b0000_0000_1_00_000;
    localparam logic [13:0] EX_I   = 14'b0000_0000_1_10_000;
    localparam logic [13:0] EX_BR  = 14'b0100_0000_1_00_100;
    localparam logic [13:0] EX_J   = 14'b0000_0000_0_00_000;
    localparam logic [13:0] EX_U   = 14'b0000_0000_0_10_000;
    localparam logic [13:0] EX_NOP = 14'b1000_0000_0_01_000;
    localparam logic [13:0] MEM_LD = 14'b0001_1000_0_00_000;
    localparam logic [13:0] MEM_SW = 14'b0001_0100_0_01_000;
    localparam logic [13:0] MEM_SR = 14'b1001_0100_0_01_000;
    localparam logic [13:0] WB_R   = 14'b1000_0001_0_01_000;
    localparam logic [13:0] WB_LD  = 14'b1000_0011_0_01_000;
    localparam logic [13:0] WB_JAL = 14'b1000_0001_0_00_100;
    localparam logic [13:0] WB_JR  = 14'b1000_0001_1_10_000;
    localparam logic [13:0] FLT    = 14'b0000_0000_0_00_001;
`ifdef ECALL_HALT_EN
    localparam logic [13:0] HLT    = 14'b0000_0000_0_00_010;
`endif

    localparam logic [6:0] ADD = 7'b0110011, ADDI = 7'b0010011, LW = 7'b0000011;
    localparam logic [6:0] SW = 7'b0100011, BEQ = 7'b1100011, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111, ECALL = 7'b1110011;
    localparam logic [6:0] FENCE = 7'b0001111;

    logic [13:0] exp_q[$];
    string       name_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    wire [13:0] act = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
                       mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
                       is_halted, mem_fault};

    // Monitor: outputs are valid every cycle, so one expectation is consumed per falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [13:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_tests++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: outputs=%b expected=%b", nm, act, e);
            end
        end
    end

    task automatic step(input logic [6:0] op, input logic rdy, input logic bc,
                        input logic rn, input logic [13:0] e, input string nm);
        @(posedge clk);
        #1;
        part_of_inst = op;
        mem_ready    = rdy;
        bcond        = bc;
        reset_n      = rn;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        reset_n      = 1'b0;
        part_of_inst = ADD;
        mem_ready    = 1'b0;
        bcond        = 1'b0;

        // Reset: IF values, no ir_write strobe even with mem_ready high
        step(ADD, 1'b1, 1'b0, 1'b0, IF_W, "reset_if");
        step(ADD, 1'b1, 1'b0, 1'b0, IF_W, "reset_if2");

        // ADD: IF, ID, EX, WB
        step(ADD, 1'b1, 1'b0, 1'b1, IF_R, "add_if");
        step(ADD, 1'b1, 1'b0, 1'b1, ID_S, "add_id");
        step(ADD, 1'b1, 1'b0, 1'b1, EX_R, "add_ex");
        step(ADD, 1'b1, 1'b0, 1'b1, WB_R, "add_wb");

        // LOAD with three MEM wait cycles
        step(LW, 1'b1, 1'b0, 1'b1, IF_R, "lw_if");
        step(LW, 1'b1, 1'b0, 1'b1, ID_S, "lw_id");
        step(LW, 1'b1, 1'b0, 1'b1, EX_I, "lw_ex");
        for (int i = 0; i < 3; i++) step(LW, 1'b0, 1'b0, 1'b1, MEM_LD, "lw_mem_wait");
        step(LW, 1'b1, 1'b0, 1'b1, MEM_LD, "lw_mem_done");
        step(LW, 1'b1, 1'b0, 1'b1, WB_LD, "lw_wb");

        // BRANCH taken, then not taken (next IF advances PC)
        step(BEQ, 1'b1, 1'b1, 1'b1, IF_R, "beq_t_if");
        step(BEQ, 1'b1, 1'b1, 1'b1, ID_S, "beq_t_id");
        step(BEQ, 1'b1, 1'b1, 1'b1, EX_BR, "beq_t_ex");
        step(BEQ, 1'b1, 1'b0, 1'b1, IF_R, "beq_nt_if");
        step(BEQ, 1'b1, 1'b0, 1'b1, ID_S, "beq_nt_id");
        step(BEQ, 1'b1, 1'b0, 1'b1, EX_BR, "beq_nt_ex");
        step(ADDI, 1'b0, 1'b0, 1'b1, IF_W, "after_nt_wait");
        step(ADDI, 1'b1, 1'b0, 1'b1, IF_RA, "after_nt_if_adv");
        step(ADDI, 1'b1, 1'b0, 1'b1, ID_S, "addi_id");
        step(ADDI, 1'b1, 1'b0, 1'b1, EX_I, "addi_ex");
        step(ADDI, 1'b1, 1'b0, 1'b1, WB_R, "addi_wb");

        // STORE, no wait
        step(SW, 1'b1, 1'b0, 1'b1, IF_R, "sw_if");
        step(SW, 1'b1, 1'b0, 1'b1, ID_S, "sw_id");
        step(SW, 1'b1, 1'b0, 1'b1, EX_I, "sw_ex");
        step(SW, 1'b1, 1'b0, 1'b1, MEM_SR, "sw_mem_done");

        // JAL, JALR, LUI
        step(JAL, 1'b1, 1'b0, 1'b1, IF_R, "jal_if");
        step(JAL, 1'b1, 1'b0, 1'b1, ID_S, "jal_id");
        step(JAL, 1'b1, 1'b0, 1'b1, EX_J, "jal_ex");
        step(JAL, 1'b1, 1'b0, 1'b1, WB_JAL, "jal_wb");
        step(JALR, 1'b1, 1'b0, 1'b1, IF_R, "jalr_if");
        step(JALR, 1'b1, 1'b0, 1'b1, ID_S, "jalr_id");
        step(JALR, 1'b1, 1'b0, 1'b1, EX_I, "jalr_ex");
        step(JALR, 1'b1, 1'b0, 1'b1, WB_JR, "jalr_wb");
        step(LUI, 1'b1, 1'b0, 1'b1, IF_R, "lui_if");
        step(LUI, 1'b1, 1'b0, 1'b1, ID_S, "lui_id");
        step(LUI, 1'b1, 1'b0, 1'b1, EX_U, "lui_ex");
        step(LUI, 1'b1, 1'b0, 1'b1, WB_R, "lui_wb");

        // Unknown opcode behaves as NOP
        step(FENCE, 1'b1, 1'b0, 1'b1, IF_R, "nop_if");
        step(FENCE, 1'b1, 1'b0, 1'b1, ID_S, "nop_id");
        step(FENCE, 1'b1, 1'b0, 1'b1, EX_NOP, "nop_ex");

        // ECALL
        step(ECALL, 1'b1, 1'b0, 1'b1, IF_R, "ecall_if");
        step(ECALL, 1'b1, 1'b0, 1'b1, ID_S, "ecall_id");
`ifdef ECALL_HALT_EN
        for (int i = 0; i < 22; i++) step(ECALL, 1'b1, 1'b0, 1'b1, HLT, "ecall_halt");
        step(ADD, 1'b1, 1'b0, 1'b0, IF_W, "halt_reset");
`else
        step(ECALL, 1'b1, 1'b0, 1'b1, EX_NOP, "ecall_nop_ex");
`endif

        // mem_ready arrives exactly at count 15: ready wins
        for (int i = 0; i < 15; i++) step(ADD, 1'b0, 1'b0, 1'b1, IF_W, "if_wait15");
        step(ADD, 1'b1, 1'b0, 1'b1, IF_R, "if_ready_at15");
        step(ADD, 1'b1, 1'b0, 1'b1, ID_S, "add2_id");
        step(ADD, 1'b1, 1'b0, 1'b1, EX_R, "add2_ex");
        step(ADD, 1'b1, 1'b0, 1'b1, WB_R, "add2_wb");

        // mem_ready held low in IF: FAULT after cycle 16, sticky
        for (int i = 0; i < 16; i++) step(ADD, 1'b0, 1'b0, 1'b1, IF_W, "if_wait16");
        for (int i = 0; i < 4; i++)  step(ADD, 1'b1, 1'b0, 1'b1, FLT, "fault_sticky");
        step(ADD, 1'b1, 1'b0, 1'b0, IF_W, "fault_reset");

        // STORE interrupted by reset mid-MEM
        step(SW, 1'b1, 1'b0, 1'b1, IF_R, "sw2_if");
        step(SW, 1'b1, 1'b0, 1'b1, ID_S, "sw2_id");
        step(SW, 1'b1, 1'b0, 1'b1, EX_I, "sw2_ex");
        step(SW, 1'b0, 1'b0, 1'b1, MEM_SW, "sw2_mem_wait");
        step(SW, 1'b0, 1'b0, 1'b1, MEM_SW, "sw2_mem_wait2");
        step(SW, 1'b1, 1'b0, 1'b0, IF_W, "sw2_reset_abort");
        step(ADD, 1'b1, 1'b0, 1'b1, IF_R, "restart_if");
        step(ADD, 1'b1, 1'b0, 1'b1, ID_S, "restart_id");

        repeat (2) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
